// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store bus controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/lsu_store_align.sv
// Byte-enable / store-lane generation and misalignment detection for one access.
module lsu_store_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lsb_i,
   input  logic [2:0]  func3_i,
   input  logic [31:0] wdata_i,
   input  logic        is_store_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o
);

   logic byte_s;
   logic half_s;
   logic word_s;

   // Size decode, misalignment and lane replication
   always_comb begin
      byte_s     = (func3_i == F3_B) | (func3_i == F3_BU);
      half_s     = (func3_i == F3_H) | (func3_i == F3_HU);
      word_s     = (func3_i[1:0] == F3_W[1:0]);
      misalign_o = (half_s & addr_lsb_i[0]) | (word_s & (addr_lsb_i != 2'b00));
      be_o       = BE_ALL;
      wdata_o    = wdata_i;
      if (!is_store_i) begin
         be_o    = BE_ALL;
         wdata_o = wdata_i;
      end else if (byte_s) begin
         be_o    = 4'b0001 << addr_lsb_i;
         wdata_o = {4{wdata_i[7:0]}};
      end else if (half_s) begin
         be_o    = 4'b0011 << {addr_lsb_i[1], 1'b0};
         wdata_o = {2{wdata_i[15:0]}};
      end else begin
         be_o    = BE_ALL;
         wdata_o = wdata_i;
      end
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store bus controller: launches one valid/ack transaction per
// access, stalls while it is outstanding and hands the captured word onward.
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  func3_i,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  addr_lsb_o,
   output logic [2:0]  func3_o,
   output logic        rdata_valid_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

   lsu_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  lsb_q, lsb_d;
   logic [2:0]  f3_q, f3_d;
   logic        err_q, err_d;
   logic        flushed_q, flushed_d;

   logic        access_s;
   logic        mis_s;
   logic [3:0]  al_be_s;
   logic [31:0] al_wdata_s;

   lsu_store_align u_align (
      .addr_lsb_i (addr_i[1:0]),
      .func3_i    (func3_i),
      .wdata_i    (wdata_i),
      .is_store_i (mem_write_i),
      .be_o       (al_be_s),
      .wdata_o    (al_wdata_s),
      .misalign_o (mis_s)
   );

   // Next-state, capture and output decode
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      bus_be_d      = bus_be_q;
      we_d          = we_q;
      rdata_d       = rdata_q;
      lsb_d         = lsb_q;
      f3_d          = f3_q;
      err_d         = err_q;
      flushed_d     = flushed_q;
      access_s      = mem_read_i | mem_write_i;
      bus_req_o     = 1'b0;
      stall_o       = 1'b0;
      misalign_o    = 1'b0;
      rdata_valid_o = 1'b0;
      bus_err_o     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            misalign_o = access_s & mis_s & ~flush_i;
            if (access_s && !mis_s && !flush_i) begin
               stall_o     = 1'b1;
               state_d     = ST_REQ;
               cnt_d       = 16'd0;
               bus_addr_d  = {addr_i[31:2], 2'b00};
               bus_wdata_d = al_wdata_s;
               bus_be_d    = al_be_s;
               we_d        = mem_write_i;
               lsb_d       = addr_i[1:0];
               f3_d        = func3_i;
               err_d       = 1'b0;
               flushed_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            bus_req_o = 1'b1;
            stall_o   = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            flushed_d = flushed_q | flush_i;
            if (bus_ack_i) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  rdata_d = bus_rdata_i;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               rdata_d = 32'd0;
               err_d   = 1'b1;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DONE: begin
            // A flush seen during REQ or in this retire cycle silences both strobes
            rdata_valid_o = ~we_q & ~err_q & ~flushed_q & ~flush_i;
            bus_err_o     = err_q & ~flushed_q & ~flush_i;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and capture registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 16'd0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_be_q    <= 4'd0;
         we_q        <= 1'b0;
         rdata_q     <= 32'd0;
         lsb_q       <= 2'd0;
         f3_q        <= 3'd0;
         err_q       <= 1'b0;
         flushed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         we_q        <= we_d;
         rdata_q     <= rdata_d;
         lsb_q       <= lsb_d;
         f3_q        <= f3_d;
         err_q       <= err_d;
         flushed_q   <= flushed_d;
      end
   end

   assign bus_we_o    = we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_be_o    = bus_be_q;
   assign rdata_o     = rdata_q;
   assign addr_lsb_o  = lsb_q;
   assign func3_o     = f3_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: a default instance plus a TIMEOUT=4 instance.
module tb_lsu_bus_ctrl;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  lsb;
      logic [2:0]  f3;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd1 = 1'b0, wr1 = 1'b0, ack1 = 1'b0;
   logic        rd2 = 1'b0, wr2 = 1'b0, ack2 = 1'b0;
   logic [31:0] addr_s = 32'd0, wdata_s = 32'd0, rdata_s = 32'd0;
   logic [2:0]  func3_s = 3'd0;
   logic        flush_s = 1'b0;

   logic        req1, we1, stall1, val1, mis1, err1;
   logic [31:0] baddr1, bwdata1, rdo1;
   logic [3:0]  be1;
   logic [1:0]  lsb1;
   logic [2:0]  f31;
   logic        req2, we2, stall2, val2, mis2, err2;
   logic [31:0] baddr2, bwdata2, rdo2;
   logic [3:0]  be2;
   logic [1:0]  lsb2;
   logic [2:0]  f32;

   int errors = 0;
   int checks = 0;
   bus_exp_t bus_q[$];
   rd_exp_t  rd_q[$];
   bus_exp_t cur_bus;
   logic     req_prev = 1'b0;

   always #5 clk = ~clk;

   lsu_bus_ctrl dut (
      .clk(clk), .rst_n(rst_n), .mem_read_i(rd1), .mem_write_i(wr1), .addr_i(addr_s),
      .wdata_i(wdata_s), .func3_i(func3_s), .flush_i(flush_s), .bus_req_o(req1),
      .bus_we_o(we1), .bus_addr_o(baddr1), .bus_wdata_o(bwdata1), .bus_be_o(be1),
      .bus_ack_i(ack1), .bus_rdata_i(rdata_s), .stall_o(stall1), .rdata_o(rdo1),
      .addr_lsb_o(lsb1), .func3_o(f31), .rdata_valid_o(val1), .misalign_o(mis1),
      .bus_err_o(err1)
   );

   lsu_bus_ctrl #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .mem_read_i(rd2), .mem_write_i(wr2), .addr_i(addr_s),
      .wdata_i(wdata_s), .func3_i(func3_s), .flush_i(flush_s), .bus_req_o(req2),
      .bus_we_o(we2), .bus_addr_o(baddr2), .bus_wdata_o(bwdata2), .bus_be_o(be2),
      .bus_ack_i(ack2), .bus_rdata_i(rdata_s), .stall_o(stall2), .rdata_o(rdo2),
      .addr_lsb_o(lsb2), .func3_o(f32), .rdata_valid_o(val2), .misalign_o(mis2),
      .bus_err_o(err2)
   );

   // Bus-side monitor: pop on the first request cycle, then hold every REQ cycle to it
   always @(negedge clk) begin
      if (rst_n && req1) begin
         if (!req_prev) begin
            checks++;
            if (bus_q.size() == 0) begin
               errors++;
               $display("FAIL bus_launch: got unexpected request addr=%h, required none", baddr1);
            end else begin
               cur_bus = bus_q.pop_front();
            end
         end
         checks++;
         if (baddr1 !== cur_bus.addr || we1 !== cur_bus.we || be1 !== cur_bus.be ||
             (cur_bus.we && bwdata1 !== cur_bus.wdata)) begin
            errors++;
            $display("FAIL bus_fields: got addr=%h we=%b be=%b wdata=%h, required addr=%h we=%b be=%b wdata=%h",
                     baddr1, we1, be1, bwdata1, cur_bus.addr, cur_bus.we, cur_bus.be, cur_bus.wdata);
         end
      end
      req_prev = req1;
   end

   // Load-result monitor: every rdata_valid_o strobe consumes one expectation
   always @(negedge clk) begin
      if (rst_n && val1) begin
         rd_exp_t e;
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL load_result: got unexpected rdata_valid rdata=%h, required none", rdo1);
         end else begin
            e = rd_q.pop_front();
            if (rdo1 !== e.rdata || lsb1 !== e.lsb || f31 !== e.f3) begin
               errors++;
               $display("FAIL load_result: got rdata=%h lsb=%0d f3=%b, required rdata=%h lsb=%0d f3=%b",
                        rdo1, lsb1, f31, e.rdata, e.lsb, e.f3);
            end
         end
      end
   end

   task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3, input int ack_dly,
                             input logic [31:0] rdat, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input bit flush_req, input string name);
      bus_exp_t b;
      rd_exp_t  r;
      int stalls = 0;
      int reqs = 0;
      b.addr = {addr[31:2], 2'b00}; b.we = wr; b.be = exp_be; b.wdata = exp_wd;
      bus_q.push_back(b);
      if (rd && !wr && !flush_req) begin
         r.rdata = rdat; r.lsb = addr[1:0]; r.f3 = f3;
         rd_q.push_back(r);
      end
      @(posedge clk); #1;
      rd1 = rd; wr1 = wr; addr_s = addr; wdata_s = wd; func3_s = f3;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stall1) stalls++;
         if (req1) reqs++;
         if (req1 && reqs == ack_dly) begin
            ack1 = 1'b1; rdata_s = rdat;
         end else begin
            ack1 = 1'b0;
         end
         if (req1 && flush_req) flush_s = 1'b1;
         if (!stall1) break;
      end
      @(posedge clk); #1;
      rd1 = 1'b0; wr1 = 1'b0; flush_s = 1'b0; ack1 = 1'b0;
      checks++;
      if (stalls != ack_dly + 1) begin
         errors++;
         $display("FAIL %s_stall: got %0d stall cycles, required %0d", name, stalls, ack_dly + 1);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (req1 !== 1'b0 || we1 !== 1'b0 || val1 !== 1'b0 || err1 !== 1'b0 || stall1 !== 1'b0 ||
          mis1 !== 1'b0 || baddr1 !== 32'd0 || bwdata1 !== 32'd0 || be1 !== 4'd0 ||
          rdo1 !== 32'd0 || lsb1 !== 2'd0 || f31 !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got req=%b we=%b addr=%h be=%b rdata=%h, required all zero",
                  req1, we1, baddr1, be1, rdo1);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_load_word();
      run_access(1'b1, 1'b0, 32'h100, 32'd0, 3'b010, 1, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0, "lw");
   endtask

   task automatic test_store_byte();
      run_access(1'b0, 1'b1, 32'h203, 32'h000000A5, 3'b000, 1, 32'd0, 4'b1000, 32'hA5A5A5A5, 1'b0, "sb");
      run_access(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 3'b010, 2, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, "rw_both");
   endtask

   task automatic test_halfword_misalign();
      run_access(1'b0, 1'b1, 32'h302, 32'h0000BEEF, 3'b001, 1, 32'd0, 4'b1100, 32'hBEEFBEEF, 1'b0, "sh");
      @(posedge clk); #1;
      rd1 = 1'b1; addr_s = 32'h301; func3_s = 3'b001;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (mis1 !== 1'b1 || stall1 !== 1'b0 || req1 !== 1'b0) begin
            errors++;
            $display("FAIL lh_misalign: got mis=%b stall=%b req=%b, required 1 0 0", mis1, stall1, req1);
         end
      end
      @(posedge clk); #1;
      rd1 = 1'b0; wr1 = 1'b1; addr_s = 32'h302; func3_s = 3'b010;
      @(negedge clk);
      checks++;
      if (mis1 !== 1'b1 || stall1 !== 1'b0) begin
         errors++;
         $display("FAIL sw_misalign: got mis=%b stall=%b, required 1 0", mis1, stall1);
      end
      flush_s = 1'b1;
      #1;
      checks++;
      if (mis1 !== 1'b0 || stall1 !== 1'b0) begin
         errors++;
         $display("FAIL flushed_misalign: got mis=%b stall=%b, required 0 0", mis1, stall1);
      end
      @(posedge clk); #1;
      wr1 = 1'b0; flush_s = 1'b0;
   endtask

   task automatic test_ack_delay();
      run_access(1'b1, 1'b0, 32'h102, 32'd0, 3'b000, 5, 32'h11223344, 4'b1111, 32'd0, 1'b0, "lb_slow");
   endtask

   task automatic test_ack_outside();
      @(posedge clk); #1;
      ack1 = 1'b1; rdata_s = 32'hFFFFFFFF;
      @(negedge clk);
      @(posedge clk); #1;
      ack1 = 1'b0;
      @(negedge clk);
      checks++;
      if (rdo1 !== 32'h11223344 || req1 !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: got rdata=%h req=%b, required 11223344 0", rdo1, req1);
      end
   endtask

   task automatic test_timeout();
      int reqs = 0, errs = 0, vals = 0, stalls = 0;
      @(posedge clk); #1;
      rd2 = 1'b1; addr_s = 32'h500; func3_s = 3'b010;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req2) begin ack2 = 1'b1; rdata_s = 32'h12345678; end else ack2 = 1'b0;
         if (!stall2) break;
      end
      checks++;
      if (val2 !== 1'b1 || rdo2 !== 32'h12345678) begin
         errors++;
         $display("FAIL to_preload: got valid=%b rdata=%h, required 1 12345678", val2, rdo2);
      end
      @(posedge clk); #1;
      rd2 = 1'b0; ack2 = 1'b0;
      @(posedge clk); #1;
      rd2 = 1'b1; addr_s = 32'h504;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (req2) reqs++;
         if (err2) errs++;
         if (val2) vals++;
         if (stall2) stalls++;
         if (!stall2) break;
      end
      @(posedge clk); #1;
      rd2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (err2) errs++;
         if (val2) vals++;
      end
      checks++;
      if (reqs != 4 || errs != 1 || vals != 0 || stalls != 5 || rdo2 !== 32'd0) begin
         errors++;
         $display("FAIL timeout: got req=%0d err=%0d valid=%0d stall=%0d rdata=%h, required 4 1 0 5 0",
                  reqs, errs, vals, stalls, rdo2);
      end
   endtask

   task automatic test_flush_in_req();
      run_access(1'b1, 1'b0, 32'h700, 32'd0, 3'b010, 2, 32'h55AA55AA, 4'b1111, 32'd0, 1'b1, "flush_req");
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 1'b1, 32'h800, 32'h01234567, 3'b010, 1, 32'd0, 4'b1111, 32'h01234567, 1'b0, "b2b_sw");
      run_access(1'b1, 1'b0, 32'h806, 32'd0, 3'b101, 1, 32'hABCD0000, 4'b1111, 32'd0, 1'b0, "b2b_lhu");
      run_access(1'b1, 1'b0, 32'h80B, 32'd0, 3'b100, 3, 32'h9F000000, 4'b1111, 32'd0, 1'b0, "b2b_lbu");
   endtask

   task automatic test_reset_mid_req();
      bus_exp_t b;
      b.addr = 32'h600; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'd0;
      bus_q.push_back(b);
      @(posedge clk); #1;
      rd1 = 1'b1; addr_s = 32'h600; func3_s = 3'b010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (req1) break;
      end
      #1;
      rd1 = 1'b0; rst_n = 1'b0;
      #1;
      checks++;
      if (req1 !== 1'b0 || stall1 !== 1'b0 || val1 !== 1'b0 || rdo1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_req: got req=%b stall=%b valid=%b rdata=%h, required 0 0 0 0",
                  req1, stall1, val1, rdo1);
      end
      @(negedge clk); rst_n = 1'b1;
      run_access(1'b1, 1'b0, 32'h604, 32'd0, 3'b010, 1, 32'h0BADF00D, 4'b1111, 32'd0, 1'b0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_store_byte();
      test_halfword_misalign();
      test_ack_delay();
      test_ack_outside();
      test_timeout();
      test_flush_in_req();
      test_back_to_back();
      test_reset_mid_req();
      repeat (3) @(negedge clk);
      checks++;
      if (bus_q.size() != 0 || rd_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d bus and %0d load expectations left, required 0 0",
                  bus_q.size(), rd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
MEM-stage load/store bus controller. It sits between the pipeline's MEM stage and a valid/ack data-memory bus, directly upstream of the load-extension stage. It issues word-aligned bus transactions with byte strobes and stalls the pipeline while a transaction is outstanding. It then presents captured read data, address bits [1:0] and func3 to the load-extension stage, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, cycles in REQ without ack before the transaction is aborted as a bus error (1..65535).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read_i  in  1  MEM-stage load request
mem_write_i  in  1  MEM-stage store request
addr_i  in  32  byte address
wdata_i  in  32  store data (rs2)
func3_i  in  3  RV32I funct3 of the load/store
flush_i  in  1  current MEM instruction squashed
bus_req_o  out  1  bus request
bus_we_o  out  1  1 = write
bus_addr_o  out  32  {addr_i[31:2],2'b00}
bus_wdata_o  out  32  lane-replicated store data
bus_be_o  out  4  byte enables
bus_ack_i  in  1  bus completion; rdata valid same cycle
bus_rdata_i  in  32  bus read data
stall_o  out  1  freeze pipeline
rdata_o  out  32  captured word, to load-extension read_data
addr_lsb_o  out  2  captured addr[1:0]
func3_o  out  3  captured funct3
rdata_valid_o  out  1  one-cycle load-result strobe
misalign_o  out  1  misaligned access (combinational)
bus_err_o  out  1  one-cycle timeout strobe

Behaviour:
- Reset (async, rst_n=0): state IDLE. bus_req_o, bus_we_o, rdata_valid_o and bus_err_o are 0. bus_addr_o, bus_wdata_o, bus_be_o, rdata_o, addr_lsb_o, func3_o and the timeout counter are 0. Reset mid-transaction drops bus_req_o immediately; no completion is reported.
- Misalignment: the access is misaligned when func3_i[1:0]=01 and addr_i[0]=1, or when func3_i[1:0]=10 and addr_i[1:0]!=0.
  - misalign_o = (mem_read_i|mem_write_i) & misaligned & ~flush_i, in IDLE only.
  - A misaligned access launches no transaction and raises no stall.
- Store alignment:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111.
- If mem_read_i and mem_write_i are both 1, the access is a store.
- FSM states are IDLE, REQ and DONE.
  - IDLE: a valid access (read or write, aligned, ~flush_i) moves to REQ. In the same cycle the bus outputs, addr_lsb, func3 and the direction are registered. stall_o = 1 combinationally in that cycle.
  - REQ: bus_req_o = 1. All bus outputs are held stable until the ack cycle. stall_o = 1. The counter increments each cycle.
    - bus_ack_i=1: drop req, capture bus_rdata_i into rdata_o (loads only), go to DONE.
    - Counter reaches TIMEOUT-1 without ack: drop req, rdata_o = 0, set the error flag, go to DONE.
  - DONE: stall_o = 0, so the instruction retires at the end of this cycle. Inputs still describe it and must not relaunch. Outputs in DONE:
    - rdata_valid_o = 1 for a completed, non-flushed load.
    - bus_err_o = 1 if a timeout occurred and the access is not flushed.
    - The next state is always IDLE.
- Minimum latency: request accepted in cycle T, bus_req_o in T+1, ack at the earliest in T+1, DONE in T+2. That is 2 stall cycles.
- flush_i:
  - In IDLE it blocks the launch.
  - In REQ the transaction is not abandoned; it completes per the bus rule, a sticky flushed flag is set, and DONE suppresses rdata_valid_o and bus_err_o.
- bus_ack_i outside REQ is ignored.
- rdata_o, addr_lsb_o and func3_o hold their values until the next capture.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE/REQ/DONE);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the byte-enable constant BE_ALL=4'b1111.
- One sub-module, lsu_store_align: combinational be/wdata generation and misalign detection.

Test Plan:
- LW addr 0x100, ack one cycle after req, bus_rdata 0xDEADBEEF -> stall 2 cycles; rdata_o=0xDEADBEEF, addr_lsb_o=0, rdata_valid_o pulses in DONE.
- SB addr 0x203, wdata 0x000000A5 -> bus_addr 0x200, be=1000, bus_wdata=0xA5A5A5A5, we=1; rdata_valid_o stays 0.
- SH addr 0x302 -> be=1100, wdata half-replicated. LH addr 0x301 -> misalign_o=1, no bus_req_o, no stall.
- LB with ack withheld for 5 cycles -> req and bus outputs stable 5 cycles, stall 6 cycles total, single capture.
- TIMEOUT=4 with no ack -> req drops after 4 cycles, bus_err_o pulses once, rdata_o=0.
- flush_i asserted in REQ -> transaction completes on ack, no rdata_valid_o; rst_n low mid-REQ -> bus_req_o=0 immediately, state IDLE.
